// File: rtl/rsa_ctrl_pkg.sv
// Shared types and constants for the RSA run controller.
package rsa_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StArm,
    StWait
  } state_e;

  // STATUS register bit positions
  localparam int unsigned STAT_BUSY       = 0;
  localparam int unsigned STAT_DONE       = 1;
  localparam int unsigned STAT_TIMEOUT    = 2;
  localparam int unsigned STAT_IGNORED    = 3;
  localparam int unsigned STAT_ABORTED    = 4;
  localparam int unsigned STAT_RUNCNT_LSB = 16;

  // START register command bits
  localparam int unsigned START_BIT = 0;
  localparam int unsigned ABORT_BIT = 1;

  // Number of 32-bit RESULT words for a given engine width
  function automatic int unsigned result_words(int unsigned rsa_width);
    return rsa_width / 32;
  endfunction

endpackage

// File: rtl/rsa_run_ctrl_if.sv
// Simple register bus between the AXI4-Lite supporter and the run controller.
interface rsa_run_ctrl_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic              wr;
  logic [ADDR_W-1:0] wrAddr;
  logic [31:0]       wrData;
  logic              rd;
  logic [ADDR_W-1:0] rdAddr;
  logic [31:0]       rdData;

  modport master (
    output wr, wrAddr, wrData, rd, rdAddr,
    input  rdData
  );

  // Reads have no side effects, so the slave only needs the read address.
  modport slave (
    input  wr, wrAddr, wrData, rdAddr,
    output rdData
  );
endinterface

// File: rtl/rsa_word_mux.sv
// Selects one 32-bit word of a wide result; out-of-range indices read as zero.
module rsa_word_mux
  import rsa_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned IDX_W = 14
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [IDX_W-1:0] i_idx,
  output logic [31:0]      o_word
);
  localparam int unsigned Words = result_words(WIDTH);

  // Word select with zero fill beyond the last word
  always_comb begin
    o_word = '0;
    for (int unsigned i = 0; i < Words; i++) begin
      if (i_idx == IDX_W'(i)) o_word = i_data[32*i +: 32];
    end
  end
endmodule

// File: rtl/rsa_run_ctrl.sv
// Register-mapped run controller for the modular exponentiation engine.
// Optional cycle counter built when RSA_CYCLE_COUNT_EN is defined.
module rsa_run_ctrl
  import rsa_ctrl_pkg::*;
#(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 16,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned RSA_WIDTH          = 128,
  parameter int unsigned LAUNCH_CYCLES      = 2,
  parameter int unsigned TIMEOUT_CYCLES     = 1000000,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] START_ADDR  = 16'hFFFC,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] KEY_ADDR    = 16'hFFF8,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] STATUS_ADDR = 16'hFFF4,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] RUNS_ADDR   = 16'hFFF0,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] CYCLES_ADDR = 16'hFFEC,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] RESULT_BASE = 16'hFF00
) (
  input  logic                 clk,
  input  logic                 reset,
  rsa_run_ctrl_if.slave        bus,
  output logic [31:0]          key_select,
  output logic                 eng_reset,
  input  logic                 eng_ready,
  input  logic [RSA_WIDTH-1:0] eng_c,
  output logic                 busy
);
  localparam int unsigned AW      = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned LaunchW = (LAUNCH_CYCLES > 1) ? $clog2(LAUNCH_CYCLES) : 1;
  localparam int unsigned WaitW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e               r_state;
  logic [31:0]          r_key_pending, r_key_select, r_runs, r_run_cnt;
  logic [RSA_WIDTH-1:0] r_result;
  logic                 r_done, r_timeout, r_ignored, r_aborted, r_eng_reset;
  logic [LaunchW-1:0]   r_launch_cnt;
  logic [WaitW-1:0]     r_wait_cnt;

  logic w_busy, w_wr_start, w_cmd_start, w_cmd_abort, w_accept, w_res_hit;
  logic [AW-1:0]                 w_res_off;
  logic [31:0]                   w_res_word, w_cycles, w_status;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_data;

  assign w_busy      = (r_state != StIdle);
  assign w_wr_start  = bus.wr && (bus.wrAddr == START_ADDR);
  assign w_cmd_start = w_wr_start && bus.wrData[START_BIT];
  assign w_cmd_abort = w_wr_start && bus.wrData[ABORT_BIT];
  assign w_accept    = w_cmd_start && !w_busy;

  assign busy       = w_busy;
  assign eng_reset  = r_eng_reset;
  assign key_select = r_key_select;

  // Plain configuration registers written over the bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key_pending <= '0;
      r_runs        <= 32'd1;
    end else if (bus.wr) begin
      if (bus.wrAddr == KEY_ADDR)  r_key_pending <= bus.wrData;
      if (bus.wrAddr == RUNS_ADDR) r_runs        <= bus.wrData;
    end
  end

  // Run sequencing FSM with registered engine controls and sticky status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_key_select <= '0;
      r_run_cnt    <= '0;
      r_result     <= '0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_ignored    <= 1'b0;
      r_aborted    <= 1'b0;
      r_eng_reset  <= 1'b0;
      r_launch_cnt <= '0;
      r_wait_cnt   <= '0;
    end else begin
      if (w_cmd_start && w_busy && !w_cmd_abort) r_ignored <= 1'b1;
      if (w_busy && w_cmd_abort) begin
        // Abort beats any capture or launch in the same cycle
        r_eng_reset <= 1'b1;
        r_state     <= StIdle;
        r_aborted   <= 1'b1;
      end else begin
        unique case (r_state)
          StIdle: begin
            r_eng_reset <= 1'b0;
            if (w_cmd_start) begin
              r_done       <= 1'b0;
              r_timeout    <= 1'b0;
              r_aborted    <= 1'b0;
              r_ignored    <= 1'b0;
              r_result     <= '0;
              r_key_select <= r_key_pending;
              r_run_cnt    <= (r_runs == '0) ? 32'd1 : r_runs;
              r_launch_cnt <= '0;
              r_eng_reset  <= 1'b1;
              r_state      <= StLaunch;
            end
          end
          StLaunch: begin
            if (r_launch_cnt == LaunchW'(LAUNCH_CYCLES - 1)) begin
              r_eng_reset <= 1'b0;
              r_state     <= StArm;
            end else begin
              r_launch_cnt <= r_launch_cnt + 1'b1;
            end
          end
          StArm: begin
            // A ready left over from the previous run is not looked at here
            r_wait_cnt <= '0;
            r_state    <= StWait;
          end
          StWait: begin
            if (eng_ready) begin
              r_result  <= eng_c;
              r_run_cnt <= r_run_cnt - 32'd1;
              if (r_run_cnt > 32'd1) begin
                r_launch_cnt <= '0;
                r_eng_reset  <= 1'b1;
                r_state      <= StLaunch;
              end else begin
                r_done  <= 1'b1;
                r_state <= StIdle;
              end
            end else if (r_wait_cnt == WaitW'(TIMEOUT_CYCLES - 1)) begin
              r_eng_reset <= 1'b1;
              r_timeout   <= 1'b1;
              r_state     <= StIdle;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

`ifdef RSA_CYCLE_COUNT_EN
  logic [31:0] r_cycles;

  // Saturating count of WAIT cycles over all runs of one start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycles <= '0;
    end else if (w_accept) begin
      r_cycles <= '0;
    end else if (r_state == StWait && r_cycles != '1) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign w_cycles = r_cycles;
`else
  assign w_cycles = '0;
`endif

  assign w_res_off = bus.rdAddr - RESULT_BASE;
  assign w_res_hit = (bus.rdAddr >= RESULT_BASE) && (w_res_off[1:0] == 2'b00);

  rsa_word_mux #(
    .WIDTH (RSA_WIDTH),
    .IDX_W (AW - 2)
  ) u_word_mux (
    .i_data (r_result),
    .i_idx  (w_res_off[AW-1:2]),
    .o_word (w_res_word)
  );

  // Combinational read decode; control registers win over the result window
  always_comb begin
    w_status                     = '0;
    w_status[STAT_BUSY]          = w_busy;
    w_status[STAT_DONE]          = r_done;
    w_status[STAT_TIMEOUT]       = r_timeout;
    w_status[STAT_IGNORED]       = r_ignored;
    w_status[STAT_ABORTED]       = r_aborted;
    w_status[STAT_RUNCNT_LSB+:16] = r_run_cnt[15:0];

    w_rd_data = '0;
    if (bus.rdAddr == STATUS_ADDR)      w_rd_data = w_status;
    else if (bus.rdAddr == KEY_ADDR)    w_rd_data = r_key_pending;
    else if (bus.rdAddr == RUNS_ADDR)   w_rd_data = r_runs;
    else if (bus.rdAddr == CYCLES_ADDR) w_rd_data = w_cycles;
    else if (w_res_hit)                 w_rd_data = w_res_word;
  end

  assign bus.rdData = w_rd_data;
endmodule

// File: tb/tb_rsa_run_ctrl.sv
// Scoreboard bench for rsa_run_ctrl: reads and engine pulses are checked by monitors.
module tb_rsa_run_ctrl;
  localparam int unsigned AW = 16;
  localparam int unsigned RW = 128;

  localparam logic [15:0] A_START = 16'hFFFC, A_KEY = 16'hFFF8, A_STAT = 16'hFFF4;
  localparam logic [15:0] A_RUNS = 16'hFFF0, A_CYC = 16'hFFEC, A_RES = 16'hFF00;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_exp_t;

  typedef struct {
    int          len;
    logic [31:0] key;
  } pulse_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   key_select;
  logic          eng_reset, eng_ready, busy;
  logic [RW-1:0] eng_c;

  int n_checks = 0;
  int n_errors = 0;

  rd_exp_t rd_q[$];
  pulse_t  pq[$];

  rsa_run_ctrl_if #(.ADDR_W(AW)) bus ();

  rsa_run_ctrl #(
    .C_S_AXI_ADDR_WIDTH (AW),
    .RSA_WIDTH          (RW),
    .LAUNCH_CYCLES      (2),
    .TIMEOUT_CYCLES     (50)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .key_select (key_select),
    .eng_reset  (eng_reset),
    .eng_ready  (eng_ready),
    .eng_c      (eng_c),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Engine model: ready comes eng_delay+1 cycles after eng_reset falls;
  // each rising eng_reset selects the next result from c_tab.
  logic [15:0]   eng_delay = 16'd1000;
  logic [15:0]   e_cnt = 16'hFFFF;
  logic          prev_rst = 1'b0;
  logic [3:0]    pulse_no = 4'd0;
  logic [RW-1:0] c_tab [16];

  always @(posedge clk) begin
    prev_rst <= eng_reset;
    if (eng_reset && !prev_rst) pulse_no <= pulse_no + 4'd1;
    if (eng_reset) e_cnt <= 16'd0;
    else if (e_cnt != 16'hFFFF) e_cnt <= e_cnt + 16'd1;
  end

  assign eng_ready = !eng_reset && (e_cnt == eng_delay + 16'd1);
  assign eng_c     = c_tab[pulse_no];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cyc(input logic [31:0] v);
`ifdef RSA_CYCLE_COUNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  // Read monitor: every rd strobe pops one expected value
  always @(negedge clk) begin
    rd_exp_t e;
    if (bus.rd) begin
      if (rd_q.size() == 0) begin
        chk("rd_unexpected", bus.rdData, 32'hDEAD_BEEF);
      end else begin
        e = rd_q.pop_front();
        chk(e.name, bus.rdData, e.exp);
      end
    end
  end

  // Pulse monitor: measures each eng_reset pulse and the key presented with it
  int plen = 0;
  always @(negedge clk) begin
    pulse_t p;
    if (eng_reset) begin
      plen <= plen + 1;
    end else if (plen != 0) begin
      plen <= 0;
      if (pq.size() == 0) begin
        chk("pulse_unexpected", 32'(plen), 32'd0);
      end else begin
        p = pq.pop_front();
        chk("pulse_len", 32'(plen), 32'(p.len));
        chk("pulse_key", key_select, p.key);
      end
    end
  end

  task automatic wr_reg(input logic [15:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.wr = 1'b1; bus.wrAddr = a; bus.wrData = d;
    @(posedge clk); #1;
    bus.wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [15:0] a, input logic [31:0] exp, input string name);
    rd_exp_t e;
    @(posedge clk); #1;
    e.name = name; e.exp = exp;
    rd_q.push_back(e);
    bus.rd = 1'b1; bus.rdAddr = a;
    @(posedge clk); #1;
    bus.rd = 1'b0;
  endtask

  task automatic push_pulse(input int len, input logic [31:0] key);
    pulse_t p;
    p.len = len; p.key = key;
    pq.push_back(p);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 16; k++) begin
      c_tab[k] = {8'(k), 24'h3, 8'(k), 24'h2, 8'(k), 24'h1, 8'(k), 24'h0};
    end
    c_tab[1] = 128'h01234567_76543210_FEDCBA98_89ABCDEF;
    bus.wr = 1'b0; bus.rd = 1'b0;
    bus.wrAddr = '0; bus.wrData = '0; bus.rdAddr = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_eng_reset", 32'(eng_reset), 32'd0);
    chk("rst_key_select", key_select, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    rd_reg(A_STAT, 32'h0, "rst_status");
    rd_reg(A_RES, 32'h0, "rst_result0");
    rd_reg(A_RUNS, 32'h1, "rst_runs");
    rd_reg(A_CYC, 32'h0, "rst_cycles");
    rd_reg(16'h0010, 32'h0, "unmapped");

    // Single run, RUNS=0 treated as one
    wr_reg(A_KEY, 32'd3);
    wr_reg(A_RUNS, 32'd0);
    eng_delay = 16'd20;
    push_pulse(2, 32'd3);
    wr_reg(A_START, 32'h1);
    wait_idle("run1_idle", 200);
    rd_reg(A_RES + 16'h0, 32'h89ABCDEF, "run1_word0");
    rd_reg(A_RES + 16'h4, 32'hFEDCBA98, "run1_word1");
    rd_reg(A_RES + 16'h8, 32'h76543210, "run1_word2");
    rd_reg(A_RES + 16'hC, 32'h01234567, "run1_word3");
    rd_reg(A_RES + 16'h10, 32'h0, "run1_word4_zero");
    rd_reg(A_STAT, 32'h2, "run1_status");
    rd_reg(A_CYC, cyc(32'd21), "run1_cycles");
    rd_reg(A_KEY, 32'd3, "key_readback");

    // Three back-to-back runs
    wr_reg(A_RUNS, 32'd3);
    eng_delay = 16'd10;
    repeat (3) push_pulse(2, 32'd3);
    wr_reg(A_START, 32'h1);
    rd_reg(A_STAT, 32'h0003_0001, "runs3_status_mid");
    wait_idle("runs3_idle", 300);
    rd_reg(A_RES + 16'h0, 32'h04000000, "runs3_word0");
    rd_reg(A_RES + 16'hC, 32'h04000003, "runs3_word3");
    rd_reg(A_STAT, 32'h2, "runs3_status");
    rd_reg(A_CYC, cyc(32'd33), "runs3_cycles");
    rd_reg(A_RUNS, 32'd3, "runs_readback");

    // Start while busy and key change mid-run
    wr_reg(A_RUNS, 32'd1);
    eng_delay = 16'd15;
    push_pulse(2, 32'd3);
    wr_reg(A_START, 32'h1);
    wr_reg(A_START, 32'h1);
    wr_reg(A_KEY, 32'd5);
    rd_reg(A_STAT, 32'h0001_0009, "ign_status_mid");
    chk("ign_key_select_mid", key_select, 32'd3);
    wait_idle("ign_idle", 200);
    rd_reg(A_STAT, 32'h0000_000A, "ign_status_done");
    rd_reg(A_RES, 32'h05000000, "ign_word0");
    chk("ign_key_select_end", key_select, 32'd3);

    // Abort during WAIT
    eng_delay = 16'd1000;
    push_pulse(2, 32'd5);
    push_pulse(1, 32'd5);
    wr_reg(A_START, 32'h1);
    repeat (10) @(posedge clk);
    wr_reg(A_START, 32'h2);
    wait_idle("abort_idle", 20);
    rd_reg(A_STAT, 32'h0001_0010, "abort_status");
    rd_reg(A_RES, 32'h0, "abort_result");

    // Watchdog timeout, then a fresh start clears it
    push_pulse(2, 32'd5);
    push_pulse(1, 32'd5);
    wr_reg(A_START, 32'h1);
    wait_idle("timeout_idle", 200);
    rd_reg(A_STAT, 32'h0001_0004, "timeout_status");
    rd_reg(A_CYC, cyc(32'd50), "timeout_cycles");
    eng_delay = 16'd4;
    push_pulse(2, 32'd5);
    wr_reg(A_START, 32'h1);
    rd_reg(A_STAT, 32'h0001_0001, "restart_status_mid");
    wait_idle("restart_idle", 100);
    rd_reg(A_STAT, 32'h2, "restart_status");
    rd_reg(A_RES + 16'h4, 32'h0A000001, "restart_word1");
    rd_reg(A_CYC, cyc(32'd5), "restart_cycles");

    // Asynchronous reset in the middle of a launch
    wr_reg(A_KEY, 32'd7);
    wr_reg(A_RUNS, 32'd2);
    wr_reg(A_START, 32'h1);
    chk("launch_before_reset", 32'(eng_reset), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_eng_reset", 32'(eng_reset), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_key_select", key_select, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    rd_reg(A_STAT, 32'h0, "async_status");
    rd_reg(A_RUNS, 32'h1, "async_runs");
    rd_reg(A_KEY, 32'h0, "async_key");
    rd_reg(A_RES, 32'h0, "async_result");

    repeat (3) @(posedge clk);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("pulse_queue_drained", 32'(pq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rsa_run_ctrl.md
# rsa_run_ctrl

Register-mapped run controller for the modular exponentiation engine, sitting between the simple bus produced by the AXI4-Lite supporter and the `exponentiate` core. It is the parametrised successor of the single-run start/ready glue logic. It adds:
- a latched key selection per run;
- N back-to-back repeat runs;
- multi-word result readback for any RSA width;
- a watchdog timeout and an abort command;
- an optional cycle counter for timing measurement.

## Interface
Parameters:
- C_S_AXI_ADDR_WIDTH, 16, bus address width
- C_S_AXI_DATA_WIDTH, 32, bus data width (fixed 32)
- RSA_WIDTH, 128, engine operand width; multiple of 32
- LAUNCH_CYCLES, 2, engine reset pulse length, ≥1
- TIMEOUT_CYCLES, 1000000, max WAIT cycles per run
- START_ADDR 'hFFFC, KEY_ADDR 'hFFF8, STATUS_ADDR 'hFFF4, RUNS_ADDR 'hFFF0, CYCLES_ADDR 'hFFEC, RESULT_BASE 'hFF00: byte addresses

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- wr  in  1  bus write strobe, one cycle
- wrAddr  in  C_S_AXI_ADDR_WIDTH  write address
- wrData  in  32  write data
- rd  in  1  bus read strobe
- rdAddr  in  C_S_AXI_ADDR_WIDTH  read address
- rdData  out  32  read data, combinational from rdAddr
- key_select  out  32  latched key index to selector
- eng_reset  out  1  engine reset/start pulse
- eng_ready  in  1  engine done
- eng_c  in  RSA_WIDTH  engine result
- busy  out  1  run in progress

## Operation
- States: IDLE, LAUNCH, ARM, WAIT.
- KEY_ADDR write sets key_pending. On an accepted start, key_select <= key_pending; key_select stays stable until the next accepted start.
- RUNS_ADDR write sets runs (32 bit). A value of 0 is treated as 1.
- START_ADDR write:
  - wrData[0]=1 in IDLE → accepted start. Clears done, timeout, aborted and start_ignored; clears result and cycles; run_cnt <= runs; enters LAUNCH.
  - wrData[0]=1 while busy → ignored; sets start_ignored (sticky).
  - wrData[1]=1 while busy → abort. eng_reset is high one cycle, the controller enters IDLE and sets aborted. Abort takes priority over start in the same write.
- LAUNCH: eng_reset=1 for LAUNCH_CYCLES cycles, then ARM.
- ARM: one cycle with eng_reset=0 and eng_ready ignored, so a stale ready is masked. Then WAIT.
- WAIT, each cycle:
  - If eng_ready=1: result <= eng_c and run_cnt decrements. If run_cnt was >1 → LAUNCH; otherwise → IDLE and set done.
  - Else, if the wait counter reaches TIMEOUT_CYCLES: pulse eng_reset for one cycle, go to IDLE, set timeout. result holds its last captured value.
- The wait counter resets on entry to WAIT.
- STATUS read: [0] busy, [1] done, [2] timeout, [3] start_ignored, [4] aborted, [31:16] run_cnt. Reads never clear bits.
- RESULT read: RESULT_BASE+4i returns result[32i+31:32i] for i < RSA_WIDTH/32, word 0 least significant. Higher i returns 0.
- Reads of any unmapped address return 0. KEY_ADDR and RUNS_ADDR read back their stored values.
- busy = (state != IDLE).

## Timing
- Reset values:
  - state=IDLE, busy=0, eng_reset=0, key_select=0.
  - key_pending=0, runs=1, result=0, cycles=0, all status bits 0.
  - rdData is combinational and equals 0 for an unmapped rdAddr.
- Start written at edge T:
  - eng_reset is high for edges T+1 .. T+LAUNCH_CYCLES.
  - ARM occupies one cycle; WAIT is entered the cycle after.
- eng_ready sampled high at edge X:
  - result is valid and busy=0 (last run) after X.
  - Otherwise eng_reset rises after X.
- Per-run overhead between runs is LAUNCH_CYCLES+1 cycles.
- Simultaneous wr and eng_ready:
  - An ignored start still sets start_ignored while the capture proceeds.
  - Abort wins over capture; result keeps the prior value.
- Asynchronous reset mid-run: immediate return to IDLE with all reset values; eng_reset drops at once.

## Configuration
- RSA_CYCLE_COUNT_EN defined:
  - The 32-bit cycles register increments every WAIT cycle across all runs, including each ready cycle.
  - It saturates at 'hFFFFFFFF and is readable at CYCLES_ADDR.
- Undefined: no counter is built and CYCLES_ADDR reads 0.

## Structure
- Package rsa_ctrl_pkg holds:
  - the state enum;
  - STATUS bit index constants;
  - START command bit indices (START_BIT=0, ABORT_BIT=1);
  - the RESULT word-count function RSA_WIDTH/32.
- One natural sub-module, rsa_word_mux: selects a 32-bit word from the RSA_WIDTH result by word index, with a zero-fill range check.

## Test plan
- Reset, then read STATUS, RESULT_BASE and RUNS → 0, 0 and 1; busy=0, eng_reset=0.
- KEY=3, RUNS=0, start; model ready 20 cycles after ARM with c='h0123…CDEF (128 bit) → key_select=3; eng_reset high exactly 2 cycles; words 0..3 match; STATUS=done; CYCLES=21 with RSA_CYCLE_COUNT_EN.
- RUNS=3, ready after 10 cycles each → three eng_reset pulses; the result equals the third run's eng_c; CYCLES=33.
- Start while busy, then write KEY=5 mid-run → start_ignored=1; key_select stays 3; the run completes normally.
- Abort (wrData=2) during WAIT → one-cycle eng_reset; busy=0; aborted=1; done=0; result unchanged.
- TIMEOUT_CYCLES=50 with ready never asserted → timeout=1 after 50 WAIT cycles; busy=0. A following start clears timeout.
